// File: rtl/counter_sum_monitor.sv
// Threshold-crossing and wrap monitor for the summed counter value.
// Raises UP/DOWN/WRAP events into a 2-entry FIFO and tracks wrap count and maximum.
module counter_sum_monitor #(
  parameter int SIZE  = 10,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [SIZE-1:0] in_val,
  input  logic [SIZE-1:0] thresh,
  input  logic            evt_ready,
  output logic            evt_valid,
  output logic [1:0]      evt_code,
  output logic [SIZE-1:0] evt_data,
  output logic            evt_drop,
  output logic [CNT_W-1:0] wrap_cnt,
  output logic [SIZE-1:0] max_val
);

  typedef enum logic [1:0] {
    S_INIT,
    S_BELOW,
    S_ABOVE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [SIZE-1:0] r_prev;
  logic [SIZE-1:0] r_max;
  logic [CNT_W-1:0] r_wraps;
  logic            r_drop;
  logic [1:0]      r_cnt;
  logic [1:0]      r_code0;
  logic [1:0]      r_code1;
  logic [SIZE-1:0] r_data0;
  logic [SIZE-1:0] r_data1;

  logic            w_ge;
  logic            w_wrap;
  logic [1:0]      w_code;
  logic            w_pop;
  logic            w_push;
  logic [1:0]      w_slot;

  assign w_ge   = in_val >= thresh;
  assign w_wrap = en && (r_state != S_INIT) && (in_val < r_prev);

  always_comb begin
    w_state_nxt = r_state;
    w_code      = 2'b00;
    if (en) begin
      w_state_nxt = w_ge ? S_ABOVE : S_BELOW;
      unique case (r_state)
        S_BELOW: if (w_ge)  w_code = 2'b01;
        S_ABOVE: if (!w_ge) w_code = 2'b10;
        default: w_code = 2'b00;
      endcase
      // wrap outranks any crossing on the same sample
      if (w_wrap) w_code = 2'b11;
    end
  end

  assign w_pop  = (r_cnt != 2'd0) && evt_ready;
  assign w_push = (w_code != 2'b00) && ((r_cnt != 2'd2) || w_pop);
  assign w_slot = r_cnt - {1'b0, w_pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_INIT;
      r_prev  <= '0;
      r_max   <= '0;
      r_wraps <= '0;
      r_drop  <= 1'b0;
      r_cnt   <= 2'd0;
      r_code0 <= 2'b00;
      r_code1 <= 2'b00;
      r_data0 <= '0;
      r_data1 <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (en) begin
        r_prev <= in_val;
        if (in_val > r_max) r_max <= in_val;
        if (w_wrap && !(&r_wraps)) r_wraps <= r_wraps + 1'b1;
      end
      if (w_pop) begin
        r_code0 <= r_code1;
        r_data0 <= r_data1;
      end
      // push lands in the first free slot after this cycle's pop
      if (w_push) begin
        if (w_slot == 2'd0) begin
          r_code0 <= w_code;
          r_data0 <= in_val;
        end else begin
          r_code1 <= w_code;
          r_data1 <= in_val;
        end
      end
      if ((w_code != 2'b00) && !w_push) r_drop <= 1'b1;
      r_cnt <= r_cnt - {1'b0, w_pop} + {1'b0, w_push};
    end
  end

  assign evt_valid = r_cnt != 2'd0;
  assign evt_code  = evt_valid ? r_code0 : 2'b00;
  assign evt_data  = evt_valid ? r_data0 : '0;
  assign evt_drop  = r_drop;
  assign wrap_cnt  = r_wraps;
  assign max_val   = r_max;

endmodule
